chip8_audio_receiver: RTL



---
 rtl/chip8_audio_receiver_pkg.sv | 19 +
 rtl/chip8_audio_receiver_if.sv | 25 ++
 rtl/chip8_audio_receiver_sync_edge.sv | 37 +++
 rtl/chip8_audio_receiver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/chip8_audio_receiver_pkg.sv
// Shared types and defaults for the Chip8 I2S ADC capture path.
package chip8_audio_pkg;

  localparam int SAMPLE_WIDTH_DEF = 16;
  localparam int I2S_DELAY_DEF    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } rx_state_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_t;

endpackage

// File: rtl/chip8_audio_receiver_if.sv
// Stereo sample output channel: one-deep valid/ready pair plus sticky overrun.
interface chip8_audio_receiver_if
  import chip8_audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) ();

  logic [SAMPLE_WIDTH-1:0] sample_left;
  logic [SAMPLE_WIDTH-1:0] sample_right;
  logic                    sample_valid;
  logic                    sample_ready;
  logic                    overrun;
  logic                    clear_overrun;

  modport master (
    output sample_left, sample_right, sample_valid, overrun,
    input  sample_ready, clear_overrun
  );

  modport slave (
    input  sample_left, sample_right, sample_valid, overrun,
    output sample_ready, clear_overrun
  );

endinterface

// File: rtl/chip8_audio_receiver_sync_edge.sv
// Two-flop synchronizer plus a history flop, reporting level and edges of the synchronized copy.
module chip8_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;
  logic       hist_q;
  logic       hist_d;

  // Next values of the synchronizer chain and history flop.
  always_comb begin
    sync_d = {sync_q[0], d};
    hist_d = sync_q[1];
  end

  // Synchronizer and history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~hist_q;
  assign fall  = ~sync_q[1] & hist_q;

endmodule

// File: rtl/chip8_audio_receiver.sv
// I2S ADC deserializer: oversamples BCLK/LRCK and assembles left/right words into a
// one-deep output register with overrun detection.
module chip8_audio_receiver
  import chip8_audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int I2S_DELAY    = I2S_DELAY_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   bclk,
  input  logic                   adclrck,
  input  logic                   adcdat,
  chip8_audio_receiver_if.master rx_if
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam int DW = (I2S_DELAY > 0) ? $clog2(I2S_DELAY + 1) : 1;
  localparam rx_state_t START_ST = (I2S_DELAY == 0) ? SHIFT : SKIP;

  logic bclk_rise_s;
  logic lrck_lvl_s;
  logic lrck_rise_s;
  logic lrck_fall_s;
  logic lrck_edge_s;

  chip8_sync_edge u_bclk_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bclk),
    .level (),
    .rise  (bclk_rise_s),
    .fall  ()
  );

  chip8_sync_edge u_lrck_sync (
    .clk   (clk),
    .reset (reset),
    .d     (adclrck),
    .level (lrck_lvl_s),
    .rise  (lrck_rise_s),
    .fall  (lrck_fall_s)
  );

  logic [1:0]              dat_sync_q, dat_sync_d;
  rx_state_t               state_q, state_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]           skip_cnt_q, skip_cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic                    have_left_q, have_left_d;
  logic [SAMPLE_WIDTH-1:0] out_left_q, out_left_d;
  logic [SAMPLE_WIDTH-1:0] out_right_q, out_right_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  logic                    store_s;
  logic                    restart_s;
  logic                    commit_s;
  chan_t                   chan_s;
  logic [SAMPLE_WIDTH-1:0] word_s;

  assign lrck_edge_s = lrck_rise_s | lrck_fall_s;
  // On an LRCK edge the finishing word belongs to the channel before the edge.
  assign chan_s      = chan_t'(lrck_edge_s ? ~lrck_lvl_s : lrck_lvl_s);
  assign word_s      = shift_q << (SAMPLE_WIDTH - int'(bit_cnt_q));

  // Capture FSM, shift register and channel latch.
  always_comb begin
    dat_sync_d  = {dat_sync_q[0], adcdat};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    shift_d     = shift_q;
    left_d      = left_q;
    have_left_d = have_left_q;
    store_s     = 1'b0;
    restart_s   = 1'b0;
    commit_s    = 1'b0;

    if (!enable) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      skip_cnt_d  = '0;
      shift_d     = '0;
      have_left_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lrck_fall_s) begin
            restart_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        SKIP: begin
          if (lrck_edge_s) begin
            store_s   = 1'b1;
            restart_s = 1'b1;
          end else if (bclk_rise_s) begin
            if (skip_cnt_q == DW'(I2S_DELAY - 1)) begin
              state_d = SHIFT;
            end else begin
              skip_cnt_d = skip_cnt_q + DW'(1);
            end
          end else begin
            state_d = SKIP;
          end
        end
        SHIFT: begin
          if (lrck_edge_s || (bit_cnt_q == CW'(SAMPLE_WIDTH))) begin
            store_s = 1'b1;
            if (lrck_edge_s) begin
              restart_s = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end else if (bclk_rise_s) begin
            shift_d   = {shift_q[SAMPLE_WIDTH-2:0], dat_sync_q[1]};
            bit_cnt_d = bit_cnt_q + CW'(1);
          end else begin
            state_d = SHIFT;
          end
        end
        HOLD: begin
          if (lrck_edge_s) begin
            restart_s = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (restart_s) begin
        state_d    = START_ST;
        bit_cnt_d  = '0;
        skip_cnt_d = '0;
        shift_d    = '0;
      end else begin
        state_d = state_d;
      end

      if (store_s && (chan_s == CH_LEFT)) begin
        left_d      = word_s;
        have_left_d = 1'b1;
      end else if (store_s && have_left_q) begin
        commit_s    = 1'b1;
        have_left_d = 1'b0;
      end else begin
        have_left_d = have_left_d;
      end
    end
  end

  // Output register handshake and sticky overrun.
  always_comb begin
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    valid_d     = valid_q;
    overrun_d   = rx_if.clear_overrun ? 1'b0 : overrun_q;

    if (commit_s) begin
      if (!valid_q || rx_if.sample_ready) begin
        out_left_d  = left_q;
        out_right_d = word_s;
        valid_d     = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_if.sample_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dat_sync_q  <= 2'b00;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      skip_cnt_q  <= '0;
      shift_q     <= '0;
      left_q      <= '0;
      have_left_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      dat_sync_q  <= dat_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      have_left_q <= have_left_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.sample_left  = out_left_q;
  assign rx_if.sample_right = out_right_q;
  assign rx_if.sample_valid = valid_q;
  assign rx_if.overrun      = overrun_q;

endmodule
